// File: rtl/flash_rd_arbiter.sv
// Two-port round-robin arbiter in front of a single line-read flash reader.
// Latches requester pulses, merges concurrent misses to the same line into one
// flash transaction, and inserts a programmable deselect gap after each one.
module flash_rd_arbiter #(
  parameter int unsigned LINE_SIZE  = 128,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [23:0]          m0_addr,
  input  logic                 m0_rd,
  output logic                 m0_done,
  output logic [LINE_SIZE-1:0] m0_line,
  input  logic [23:0]          m1_addr,
  input  logic                 m1_rd,
  output logic                 m1_done,
  output logic [LINE_SIZE-1:0] m1_line,
  output logic [23:0]          fr_addr,
  output logic                 fr_rd,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line,
  output logic                 err
);

  localparam int unsigned OW        = $clog2(LINE_SIZE / 8);
  localparam logic [23:0] LINE_MASK = ~24'((1 << OW) - 1);
  localparam logic [3:0]  GAP_LD    = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0][23:0] paddr_q, paddr_d;
  logic [23:0]      cur_addr_q, cur_addr_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [3:0]       gap_q, gap_d;
  logic             err_q, err_d;

  logic [1:0]       rd_in;
  logic [1:0][23:0] addr_in;
  logic [1:0]       in_flight;
  logic [1:0]       done;
  logic             winner;
  logic             other;
  logic             merge;

  assign rd_in   = {m1_rd, m0_rd};
  assign addr_in = {m1_addr, m0_addr};

  // Only the granted port is in flight; a merged port is still just pending.
  assign in_flight = (state_q == S_BUSY) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign winner    = (pend_q == 2'b11) ? ~last_q : pend_q[1];
  assign other     = ~gnt_q;
  // Merge uses the registered pend, so a request arriving with fr_done never merges.
  assign merge     = pend_q[other] && (paddr_q[other] == cur_addr_q);

  assign m0_done = done[0];
  assign m1_done = done[1];
  assign m0_line = fr_line;
  assign m1_line = fr_line;
  assign err     = err_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      paddr_q    <= '0;
      cur_addr_q <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      gap_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      paddr_q    <= paddr_d;
      cur_addr_q <= cur_addr_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
    end
  end

  // Request capture, grant, completion and gap sequencing.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    paddr_d    = paddr_q;
    cur_addr_d = cur_addr_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    gap_d      = gap_q;
    err_d      = err_q;
    fr_rd      = 1'b0;
    fr_addr    = cur_addr_q;
    done       = '0;

    for (int unsigned i = 0; i < 2; i++) begin
      if (rd_in[i]) begin
        if (pend_q[i] || in_flight[i]) begin
          err_d = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          paddr_d[i] = addr_in[i] & LINE_MASK;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        fr_addr = '0;
        if (pend_q != 2'b00) begin
          fr_rd          = 1'b1;
          fr_addr        = paddr_q[winner];
          gnt_d          = winner;
          cur_addr_d     = paddr_q[winner];
          pend_d[winner] = 1'b0;
          state_d        = S_BUSY;
        end
      end
      S_BUSY: begin
        if (fr_done) begin
          last_d      = gnt_q;
          done[gnt_q] = 1'b1;
          if (merge) begin
            done[other]   = 1'b1;
            pend_d[other] = 1'b0;
          end
          if (GAP_LD == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LD;
          end
        end
      end
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// Directed testbench for flash_rd_arbiter with hand-computed expectations.
module tb_flash_rd_arbiter;

  localparam int unsigned   GAP    = 2;
  localparam logic [127:0]  LINE_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0]  LINE_B = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  m0_addr, m1_addr, fr_addr;
  logic         m0_rd, m1_rd, m0_done, m1_done;
  logic [127:0] m0_line, m1_line, fr_line;
  logic         fr_rd, fr_done, err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  flash_rd_arbiter #(.LINE_SIZE(128), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_rd(m0_rd), .m0_done(m0_done), .m0_line(m0_line),
    .m1_addr(m1_addr), .m1_rd(m1_rd), .m1_done(m1_done), .m1_line(m1_line),
    .fr_addr(fr_addr), .fr_rd(fr_rd), .fr_done(fr_done), .fr_line(fr_line),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr();
    m0_rd   = 1'b0;
    m1_rd   = 1'b0;
    fr_done = 1'b0;
  endtask

  task automatic do_reset();
    nxt(); clr(); rst = 1'b1;
    nxt(); rst = 1'b0;
  endtask

  int   cnt;
  int   grants;
  int   rdcnt;
  int   k0, k1;
  logic rq0, rq1;

  initial begin
    rst = 1'b1; clr(); m0_addr = '0; m1_addr = '0; fr_line = LINE_A;

    // Reset state and single request.
    do_reset(); smp();
    check("rst_fr_rd",   128'(fr_rd),   128'(0));
    check("rst_fr_addr", 128'(fr_addr), 128'(0));
    check("rst_m0_done", 128'(m0_done), 128'(0));
    check("rst_m1_done", 128'(m1_done), 128'(0));
    check("rst_err",     128'(err),     128'(0));
    nxt(); m0_rd = 1'b1; m0_addr = 24'h012345; smp();
    check("t1_no_early_rd", 128'(fr_rd), 128'(0));
    nxt(); clr(); smp();
    check("t1_fr_rd",   128'(fr_rd),   128'(1));
    check("t1_fr_addr", 128'(fr_addr), 128'(24'h012340));
    nxt(); clr(); smp();
    check("t1_busy_no_rd", 128'(fr_rd), 128'(0));
    nxt(); clr(); fr_done = 1'b1; fr_line = LINE_A; smp();
    check("t1_m0_done", 128'(m0_done), 128'(1));
    check("t1_m0_line", m0_line, LINE_A);
    check("t1_m1_done", 128'(m1_done), 128'(0));
    nxt(); clr(); smp();
    check("t1_done_pulse", 128'(m0_done), 128'(0));

    // Tie after reset: port 0 first, port 1 exactly GAP+1 cycles after fr_done.
    do_reset(); m0_rd = 1'b1; m0_addr = 24'h000100; m1_rd = 1'b1; m1_addr = 24'h000200; smp();
    nxt(); clr(); smp();
    check("t2_rd0",   128'(fr_rd),   128'(1));
    check("t2_addr0", 128'(fr_addr), 128'(24'h000100));
    nxt(); clr(); fr_done = 1'b1; fr_line = LINE_B; smp();
    check("t2_m0_done", 128'(m0_done), 128'(1));
    check("t2_m1_quiet", 128'(m1_done), 128'(0));
    for (int k = 0; k < int'(GAP); k++) begin
      nxt(); clr(); smp();
      check($sformatf("t2_gap%0d", k), 128'(fr_rd), 128'(0));
    end
    nxt(); clr(); smp();
    check("t2_rd1",   128'(fr_rd),   128'(1));
    check("t2_addr1", 128'(fr_addr), 128'(24'h000200));
    nxt(); clr(); fr_done = 1'b1; smp();
    check("t2_m1_done", 128'(m1_done), 128'(1));
    check("t2_m0_quiet", 128'(m0_done), 128'(0));
    check("t2_m1_line", m1_line, LINE_B);

    // Merge of two requests to the same line.
    for (int k = 0; k < 3; k++) begin nxt(); clr(); end
    nxt(); m0_rd = 1'b1; m0_addr = 24'h0004A4; m1_rd = 1'b1; m1_addr = 24'h0004A8; smp();
    nxt(); clr(); smp();
    check("t3_rd",   128'(fr_rd),   128'(1));
    check("t3_addr", 128'(fr_addr), 128'(24'h0004A0));
    nxt(); clr(); fr_done = 1'b1; smp();
    check("t3_m0_done", 128'(m0_done), 128'(1));
    check("t3_m1_done", 128'(m1_done), 128'(1));
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      nxt(); clr(); smp();
      if (fr_rd) cnt++;
    end
    check("t3_single_rd", 128'(cnt), 128'(0));

    // Fairness: each port re-requests a new line on its own done pulse.
    do_reset(); m0_rd = 1'b1; m0_addr = 24'h001000; m1_rd = 1'b1; m1_addr = 24'h002000; smp();
    grants = 0; rdcnt = -1; k0 = 1; k1 = 1; rq0 = 1'b0; rq1 = 1'b0;
    for (int cyc = 0; cyc < 300 && grants < 8; cyc++) begin
      nxt(); clr();
      if (rdcnt == 0) begin fr_done = 1'b1; rdcnt = -1; end
      else if (rdcnt > 0) rdcnt--;
      if (rq0) begin m0_rd = 1'b1; m0_addr = 24'h001000 + 24'(k0 * 16); k0++; rq0 = 1'b0; end
      if (rq1) begin m1_rd = 1'b1; m1_addr = 24'h002000 + 24'(k1 * 16); k1++; rq1 = 1'b0; end
      smp();
      if (fr_rd) begin
        check($sformatf("t4_grant%0d", grants), 128'(fr_addr[13]), 128'(grants % 2));
        grants++;
        rdcnt = 2;
      end
      if (m0_done) rq0 = 1'b1;
      if (m1_done) rq1 = 1'b1;
    end
    check("t4_grant_count", 128'(grants), 128'(8));
    check("t4_no_err", 128'(err), 128'(0));

    // Protocol error: re-request while in flight.
    do_reset(); m1_rd = 1'b1; m1_addr = 24'h003330; smp();
    nxt(); clr(); smp();
    check("t5_rd",   128'(fr_rd),   128'(1));
    check("t5_addr", 128'(fr_addr), 128'(24'h003330));
    nxt(); clr(); m1_rd = 1'b1; m1_addr = 24'h00FFF0; smp();
    check("t5_err_before", 128'(err), 128'(0));
    nxt(); clr(); smp();
    check("t5_err_set",   128'(err),     128'(1));
    check("t5_no_rd",     128'(fr_rd),   128'(0));
    check("t5_addr_kept", 128'(fr_addr), 128'(24'h003330));
    nxt(); clr(); fr_done = 1'b1; smp();
    check("t5_m1_done",  128'(m1_done), 128'(1));
    check("t5_done_addr", 128'(fr_addr), 128'(24'h003330));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      nxt(); clr(); smp();
      if (fr_rd) cnt++;
    end
    check("t5_no_extra_rd", 128'(cnt), 128'(0));
    check("t5_err_sticky",  128'(err), 128'(1));

    // Reset in the middle of a transaction.
    do_reset(); m1_rd = 1'b1; m1_addr = 24'h004440; smp();
    check("t6_err_cleared", 128'(err), 128'(0));
    nxt(); clr(); smp();
    check("t6_rd", 128'(fr_rd), 128'(1));
    for (int k = 0; k < 9; k++) begin nxt(); clr(); end
    nxt(); clr(); rst = 1'b1;
    nxt(); rst = 1'b0; clr(); fr_done = 1'b1; smp();
    check("t6_fr_rd",   128'(fr_rd),   128'(0));
    check("t6_fr_addr", 128'(fr_addr), 128'(0));
    check("t6_m0_done", 128'(m0_done), 128'(0));
    check("t6_m1_done", 128'(m1_done), 128'(0));
    nxt(); clr(); m1_rd = 1'b1; m1_addr = 24'h005550; smp();
    check("t6_pend_clear", 128'(fr_rd), 128'(0));
    nxt(); clr(); smp();
    check("t6_new_rd",   128'(fr_rd),   128'(1));
    check("t6_new_addr", 128'(fr_addr), 128'(24'h005550));
    nxt(); clr();
    nxt(); clr(); fr_done = 1'b1; smp();
    check("t6_new_done", 128'(m1_done), 128'(1));
    nxt(); clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_rd_arbiter.md
# flash_rd_arbiter

Shares one line-read flash reader (24-bit byte address, 1-cycle `rd` pulse, 1-cycle `done` pulse, `LINE_SIZE`-bit line) between two cache controllers, e.g. instruction and data cache. It latches each requester's pulse and grants the reader round-robin. Concurrent misses to the same line are merged into a single flash transaction. It enforces a programmable chip-deselect gap between transactions.

## Interface
- `LINE_SIZE`, 128: line width in bits; offset bits `OW = log2(LINE_SIZE/8)` (4 at default).
- `GAP_CYCLES`, 2: idle cycles inserted after each `fr_done` before the next `fr_rd`; 0..15; 0 = no gap.
- `clk` in 1: the single clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `m0_addr` in 24: requester 0 byte address; sampled only when `m0_rd`=1.
- `m0_rd` in 1: requester 0 read pulse (1 cycle).
- `m0_done` out 1: 1-cycle pulse; `m0_line` valid this cycle.
- `m0_line` out LINE_SIZE: line data, = `fr_line`.
- `m1_addr`, `m1_rd`, `m1_done`, `m1_line`: same as above for requester 1.
- `fr_addr` out 24: reader address, low OW bits always 0.
- `fr_rd` out 1: reader start pulse.
- `fr_done` in 1: reader completion pulse.
- `fr_line` in LINE_SIZE: reader line data.
- `err` out 1: sticky protocol-error flag.

## Operation
- Per port i: `pend[i]`, `paddr[i]` (24 b, stored as `{mi_addr[23:OW], OW'b0}`).
- `mi_rd`=1 while `pend[i]`=0 and port i not in flight: set `pend[i]`, capture `paddr[i]`.
- `mi_rd`=1 while `pend[i]`=1 or port i in flight: request dropped, `paddr[i]` unchanged, `err`<=1 (sticky until `rst`).
- Round-robin pointer `last` (1 b, last granted port).
  - Both pending: winner = ~`last`.
  - Otherwise: winner = the single pending port.
- FSM states:
  - IDLE: if `pend`!=0, assert `fr_rd`=1 and `fr_addr`=`paddr[winner]`. Register `gnt`=winner and `cur_addr`=`paddr[winner]`. Clear `pend[winner]`. Go to BUSY.
  - BUSY: `fr_rd`=0. On `fr_done`:
    - Set `last`=`gnt`.
    - Pulse `m<gnt>_done`.
    - Merge: if the other port j has `pend[j]`=1 and `paddr[j]`==`cur_addr`, also pulse `mj_done` in the same cycle and clear `pend[j]`.
    - Go to GAP, loading the gap counter with GAP_CYCLES; go straight to IDLE if GAP_CYCLES=0.
  - GAP: counter decrements each cycle; when it reaches 1, go to IDLE. `fr_rd`=0 throughout.
- Simultaneous events:
  - An `mi_rd` in the same cycle as `fr_done` is latched as pending. It is never merged in that cycle and is served by a new transaction.
  - `m0_rd` and `m1_rd` in the same cycle are both latched.
- `fr_done` outside BUSY is ignored.
- `mi_line` = `fr_line` continuously; consumers sample only on `mi_done`.
- `fr_addr`=`cur_addr` in BUSY/GAP, `paddr[winner]` in IDLE, 0 when nothing pending.

## Timing
- Reset, on the first rising edge with `rst`=1:
  - state=IDLE, `pend`=0, `paddr`=0, `cur_addr`=0, `gnt`=0, `last`=1 (port 0 wins the first tie), gap counter=0, `err`=0.
  - Outputs: `fr_rd`=0, `m0_done`=`m1_done`=0, `fr_addr`=0.
- `rst` mid-BUSY abandons the transaction with no done pulse. The flash reader shares the same reset and must be reset in the same cycle.
- Issue latency: `mi_rd` at edge t with the arbiter idle and no gap pending gives `fr_rd`=1 in cycle t+1 (combinational from `pend` and state).
- Completion: `mi_done` is combinational from `fr_done` in the same cycle; zero added latency.
- `fr_rd` is high for exactly 1 cycle per transaction. At most one transaction is outstanding.
- Minimum `fr_done`-to-next-`fr_rd` spacing: GAP_CYCLES+1 cycles.
- Worst-case wait for a port: one foreign transaction plus gap, plus its own transaction (fairness bound).

## Test plan
- Single request: `m0_rd`, `m0_addr`=0x012345 at t. Expect `fr_rd` at t+1 with `fr_addr`=0x012340. Reader `done` follows, then `m0_done` in the same cycle as `fr_done` and `m0_line`==`fr_line`. `m1_done` stays 0.
- Tie after reset: `m0_rd` (0x000100) and `m1_rd` (0x000200) in the same cycle. Expect a read of 0x000100 first. Expect a read of 0x000200 exactly GAP_CYCLES+1 cycles after the first `fr_done`. Expect `m0_done` then `m1_done`.
- Merge: `m0_rd` 0x0004A4 and `m1_rd` 0x0004A8 in the same cycle. Expect exactly one `fr_rd` (0x0004A0), and `m0_done` and `m1_done` both pulsing with the single `fr_done`.
- Fairness: both ports re-request on each of their own done pulses, with distinct lines, for 8 transactions. Expect grants to alternate 0,1,0,1,… and no port served twice in a row.
- Protocol error: `m1_rd` again while m1 is in flight. Expect `err`=1, and the original transaction completing with its original address. No extra `fr_rd` is issued; `err` stays 1 until `rst`.
- Reset mid-BUSY: assert `rst` for 1 cycle 10 cycles after `fr_rd`. Expect all outputs 0 the next cycle, no done pulse, `pend` cleared, and a fresh `m1_rd` afterwards issued normally.
